// File: rtl/sn74ls_nand_filt.sv
// -----------------------------------------------------------------------------
// sn74ls_nand_filt
//
// Purpose:
//   A bank of CH independent NAND gates, each with NIN inputs. Each gate's
//   output goes through a digital persistence filter. A channel's registered
//   output y[k] changes only after the raw NAND result has disagreed with it
//   on FILT consecutive enabled clocks. A disagreement that goes away before
//   the count completes (a glitch) is discarded, and the count starts again
//   from zero at the next disagreement.
//
// Ports:
//   clk   in   1        single clock; all state changes on its rising edge
//   rst   in   1        synchronous active-high reset (y=1s, cnt=0, chg=0)
//   a     in   CH*NIN   channel k uses a[k*NIN +: NIN]
//   en    in   1        filter advance enable (0 = freeze counts and y)
//   y     out  CH       filtered, registered NAND result per channel
//   chg   out  CH       one-clock pulse on the clock where y[k] toggles
//   busy  out  CH       channel k has a partial disagreement count (cnt != 0)
//
// The tPLH/tPHL parameters carry the original part's output delays as
// min:typ:max in ns. They are timing annotation only and do not change
// the synthesized logic.
// -----------------------------------------------------------------------------
module sn74ls_nand_filt #(
    parameter int CH       = 4,
    parameter int NIN      = 4,
    parameter int FILT     = 3,
    parameter int tPLH_min = 0,
    parameter int tPLH_typ = 12,
    parameter int tPLH_max = 24,
    parameter int tPHL_min = 0,
    parameter int tPHL_typ = 12,
    parameter int tPHL_max = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*NIN-1:0] a,
    input  logic              en,
    output logic [CH-1:0]     y,
    output logic [CH-1:0]     chg,
    output logic [CH-1:0]     busy
);

    // The counter holds 0..FILT-1. $clog2(FILT+1) is at least 1 for FILT>=1.
    localparam int             CW      = $clog2(FILT + 1);
    localparam logic [CW-1:0]  CNT_TOP = CW'(FILT - 1);

    // Delay values only need to be ordered min <= typ <= max. Nothing is
    // generated for them. This block only records the check at elaboration.
    if ((tPLH_min > tPLH_typ) || (tPLH_typ > tPLH_max) ||
        (tPHL_min > tPHL_typ) || (tPHL_typ > tPHL_max)) begin : g_delay_order_bad
    end

    genvar gi;
    for (gi = 0; gi < CH; gi++) begin : g_ch
        logic          w_raw;
        logic [CW-1:0] w_cnt_sat;
        logic [CW-1:0] w_cnt_next;
        logic          w_y_next;
        logic          w_chg_next;
        logic [CW-1:0] r_cnt;
        logic          r_y;
        logic          r_chg;

        assign w_raw = ~(&a[gi*NIN +: NIN]);

        // A corrupted counter value above FILT-1 behaves as FILT-1.
        // The next disagreement therefore completes the count immediately.
        assign w_cnt_sat = (r_cnt > CNT_TOP) ? CNT_TOP : r_cnt;

        always_comb begin
            w_cnt_next = r_cnt;
            w_y_next   = r_y;
            w_chg_next = 1'b0;
            if (en) begin
                if (w_raw == r_y) begin
                    // Agreement: any partial count was a glitch, so drop it.
                    w_cnt_next = '0;
                end else if (w_cnt_sat == CNT_TOP) begin
                    // FILTth consecutive disagreement: accept the new level.
                    w_y_next   = w_raw;
                    w_cnt_next = '0;
                    w_chg_next = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_sat + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_y   <= 1'b1;
                r_chg <= 1'b0;
            end else begin
                r_cnt <= w_cnt_next;
                r_y   <= w_y_next;
                r_chg <= w_chg_next;
            end
        end

        assign y[gi]    = r_y;
        assign chg[gi]  = r_chg;
        assign busy[gi] = (r_cnt != '0);
    end

endmodule

// File: tb/tb_sn74ls_nand_filt.sv
// -----------------------------------------------------------------------------
// tb_sn74ls_nand_filt
//
// Self-checking bench for sn74ls_nand_filt with CH=2, NIN=4 and FILT=3.
// Each transaction applies a, en and rst, then waits one rising edge.
// The bench checks y, chg and busy against a reference model. The model
// counts consecutive enabled disagreements per channel. Directed scenarios
// also check their outputs against fixed expected constants.
// -----------------------------------------------------------------------------
module tb_sn74ls_nand_filt;

    localparam int CH   = 2;
    localparam int NIN  = 4;
    localparam int FILT = 3;

    logic              clk;
    logic              rst;
    logic [CH*NIN-1:0] a;
    logic              en;
    logic [CH-1:0]     y;
    logic [CH-1:0]     chg;
    logic [CH-1:0]     busy;

    sn74ls_nand_filt #(
        .CH(CH), .NIN(NIN), .FILT(FILT),
        .tPLH_min(0), .tPLH_typ(0), .tPLH_max(0),
        .tPHL_min(0), .tPHL_typ(0), .tPHL_max(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .en  (en),
        .y   (y),
        .chg (chg),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    // Reference model state.
    // m_run[k] is the number of consecutive enabled edges at which the
    // channel's NAND disagreed with its current output.
    int          m_run [CH];
    logic [CH-1:0] m_y   = '1;
    logic [CH-1:0] m_chg = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [CH-1:0] model_busy();
        logic [CH-1:0] b;
        for (int k = 0; k < CH; k++) b[k] = (m_run[k] != 0);
        return b;
    endfunction

    // Update the model for one rising edge using the inputs applied at that edge.
    task automatic model_edge(input logic [CH*NIN-1:0] av, input logic ev, input logic rv);
        for (int k = 0; k < CH; k++) begin
            logic nand_out;
            nand_out = !((av >> (k*NIN)) % (1 << NIN) == (1 << NIN) - 1);
            if (rv) begin
                m_y[k]   = 1'b1;
                m_run[k] = 0;
                m_chg[k] = 1'b0;
            end else if (!ev) begin
                m_chg[k] = 1'b0;
            end else if (nand_out == m_y[k]) begin
                m_run[k] = 0;
                m_chg[k] = 1'b0;
            end else begin
                m_run[k] = m_run[k] + 1;
                if (m_run[k] == FILT) begin
                    m_y[k]   = nand_out;
                    m_run[k] = 0;
                    m_chg[k] = 1'b1;
                end else begin
                    m_chg[k] = 1'b0;
                end
            end
        end
    endtask

    // One transaction: drive, clock, then sample 1 ns after the edge and compare.
    task automatic step(input logic [CH*NIN-1:0] av, input logic ev, input logic rv);
        a   = av;
        en  = ev;
        rst = rv;
        @(posedge clk);
        model_edge(av, ev, rv);
        #1;
        n_txn++;
        $display("txn %0d a=%02h en=%0b rst=%0b -> y=%02b chg=%02b busy=%02b",
                 n_txn, av, ev, rv, y, chg, busy);
        check("y",    32'(y),    32'(m_y));
        check("chg",  32'(chg),  32'(m_chg));
        check("busy", 32'(busy), 32'(model_busy()));
    endtask

    task automatic do_reset(input logic [CH*NIN-1:0] av);
        step(av, 1'b1, 1'b1);
        step(av, 1'b1, 1'b1);
    endtask

    initial begin
        a   = '0;
        en  = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < CH; k++) m_run[k] = 0;
        @(negedge clk);

        // Reset with every input high. After reset both raw NANDs are 0,
        // but no count may start until rst is low.
        do_reset(8'hFF);
        check("rst_y",    32'(y),    32'h3);
        check("rst_chg",  32'(chg),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step(8'hFF, 1'b1, 1'b0);
        check("rst_first_count", 32'(busy), 32'h3);

        // Stable change on channel 0: toggles on the 3rd edge only.
        do_reset(8'h00);
        step(8'h0F, 1'b1, 1'b0);
        check("stable_e1_y", 32'(y), 32'h3);
        step(8'h0F, 1'b1, 1'b0);
        check("stable_e2_y", 32'(y), 32'h3);
        step(8'h0F, 1'b1, 1'b0);
        check("stable_e3_y",   32'(y),   32'h2);
        check("stable_e3_chg", 32'(chg), 32'h1);
        step(8'h0F, 1'b1, 1'b0);
        check("stable_e4_chg", 32'(chg), 32'h0);

        // Glitch rejection: two disagreeing clocks, then agreement again.
        do_reset(8'h00);
        step(8'h0F, 1'b1, 1'b0);
        step(8'h0F, 1'b1, 1'b0);
        check("glitch_busy_mid", 32'(busy), 32'h1);
        step(8'h07, 1'b1, 1'b0);
        check("glitch_y",    32'(y),    32'h3);
        check("glitch_busy", 32'(busy), 32'h0);
        step(8'h0F, 1'b1, 1'b0);
        step(8'h0F, 1'b1, 1'b0);
        check("glitch_restart_y", 32'(y), 32'h3);

        // Enable hold: count 1, freeze for 5 clocks, then 2 more edges.
        do_reset(8'h00);
        step(8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h0F, 1'b0, 1'b0);
        check("hold_busy", 32'(busy), 32'h1);
        check("hold_y",    32'(y),    32'h3);
        step(8'h0F, 1'b1, 1'b0);
        check("hold_resume1_y", 32'(y), 32'h3);
        step(8'h0F, 1'b1, 1'b0);
        check("hold_resume2_y",   32'(y),   32'h2);
        check("hold_resume2_chg", 32'(chg), 32'h1);

        // Reset mid-count discards the partial count.
        do_reset(8'h00);
        step(8'h0F, 1'b1, 1'b0);
        step(8'h0F, 1'b1, 1'b0);
        step(8'h0F, 1'b1, 1'b1);
        check("midrst_y",    32'(y),    32'h3);
        check("midrst_busy", 32'(busy), 32'h0);
        step(8'h0F, 1'b1, 1'b0);
        step(8'h0F, 1'b1, 1'b0);
        check("midrst_e2_y", 32'(y), 32'h3);
        step(8'h0F, 1'b1, 1'b0);
        check("midrst_e3_y", 32'(y), 32'h2);

        // Both channels driven together toggle on the same edge.
        do_reset(8'h00);
        for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b0);
        check("both_y",   32'(y),   32'h0);
        check("both_chg", 32'(chg), 32'h3);

        // Randomized phase. Each nibble is held or occasionally re-chosen.
        // The new value is biased toward 4'hF so that runs reach FILT and
        // also break early.
        begin
            logic [CH*NIN-1:0] av;
            av = 8'h00;
            for (int i = 0; i < 400; i++) begin
                for (int k = 0; k < CH; k++) begin
                    if ($urandom_range(0, 3) == 0)
                        av[k*NIN +: NIN] = ($urandom_range(0, 1) == 1) ? 4'hF
                                           : 4'($urandom_range(0, 15));
                end
                step(av, ($urandom_range(0, 7) != 0), ($urandom_range(0, 49) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
